if_pc_gen_btb: RTL
==================

# if_pc_gen_btb

Fetch-stage next-PC generator with a 32-entry direct-mapped branch target buffer (BTB). It sits directly upstream of the 1-bit local-history branch predictor.
- Drives the predictor's 5-bit lookup index.
- Consumes the predictor's taken/not-taken bit to steer fetch.
- Resolves branches in ID, and on mispredict redirects the PC and flushes IF.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits.
- BTB_IDX_W, 5, BTB/predictor index width. Index is pc[BTB_IDX_W+1:2].
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- stall  in  1  pipeline stall (includes branch hazard stall). Holds the PC and blocks resolution.
- brch_instr_detectd_IF  in  1  the instruction at pc_IF is a branch.
- prediction  in  1  predictor output for pc_IF (already gated by brch_instr_detectd_IF).
- brch_instr_detectd_ID  in  1  the ID-stage instruction is a branch.
- actual_brch_result  in  1  ID-stage branch outcome (1 = taken).
- brch_target_ID  in  ADDR_W  computed target of the ID branch.
- pc_IF  out  ADDR_W  current fetch address.
- branch_addr_lw_5b  out  BTB_IDX_W  pc_IF[BTB_IDX_W+1:2], sent to the predictor.
- flush_IF  out  1  squash the instruction in IF.
- mispredict  out  1  one-cycle pulse on a detected mispredict.

## Operation
- The BTB entry holds a valid bit, tag = pc[ADDR_W-1:BTB_IDX_W+2], and target[ADDR_W-1:2]. Target bits [1:0] are always 0.
- Lookup is combinational on pc_IF. hit = valid and tag match.
- pred_taken_IF = prediction & brch_instr_detectd_IF & hit. A taken prediction with a BTB miss is treated as not-taken.
- IF→ID tracking registers advance when !stall and no flush:
  - pred_taken_ID <= pred_taken_IF
  - pc4_ID <= pc_IF+4
  - A flush clears pred_taken_ID.
- Resolution is valid when brch_instr_detectd_ID & !stall & state==RUN.
  - mispredict = resolve & (actual_brch_result != pred_taken_ID).
  - On mispredict, the correct PC is brch_target_ID if taken, else pc4_ID.
- BTB update: on resolve & actual_brch_result, write index/tag from pc4_ID-4 and target = brch_target_ID. Entries are never invalidated except by reset.
- Next-PC priority, highest first: rst → RESET_PC; mispredict → correct PC; stall → hold; pred_taken_IF → BTB target; else pc_IF+4.
- Arithmetic is modulo 2^ADDR_W: pc 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- FSM states:
  - BOOT: one cycle after reset release. pc_IF = RESET_PC, flush_IF=1, no resolution. Goes to RUN.
  - RUN: normal operation. A mispredict goes to RECOVER.
  - RECOVER: one cycle. flush_IF=1, resolution suppressed (ID holds a bubble). Goes to RUN; a stall holds RECOVER.

## Timing
- Reset values:
  - pc_IF=RESET_PC, state=BOOT, pred_taken_ID=0, pc4_ID=0.
  - mispredict=0; flush_IF=1 while rst/BOOT.
  - All BTB valid bits = 0.
- Redirect latency: a mispredict in cycle N gives the corrected pc_IF in cycle N+1. flush_IF is combinationally high in cycle N (kills the wrong-path fetch) and high in N+1 (RECOVER).
- Predicted-taken redirect: zero bubbles. The BTB target appears at pc_IF the next cycle.
- Same-cycle BTB write and lookup to the same index: the lookup sees the old contents.
- Mispredict outranks stall. Resolution cannot occur under stall, so a mispredict never coincides with a stall.
- rst asserted mid-operation: all state returns to reset values on that edge, including any in-flight RECOVER.

## Structure
- Package if_pc_pkg holds:
  - state enum {BOOT, RUN, RECOVER}
  - RESET_PC default
  - BTB entry struct typedef {valid, tag, target}
- Sub-module btb_dm: the 32-entry array. One combinational read port, one synchronous write port, synchronous reset clears the valid bits.

## Test plan
- Reset: hold rst 3 cycles, then release. Expect pc_IF=0 with flush_IF=1 for 1 cycle, then 4, 8, 12 with no flush.
- Cold taken branch at 0x40 with target 0x100, BTB empty: predicted not-taken, resolves taken. Expect mispredict pulse, pc_IF=0x100 next cycle, 2 flush cycles, BTB[16] written.
- Same branch refetched with prediction=1: pc_IF goes 0x40→0x100 with no flush and no mispredict.
- Predicted taken (BTB hit) but actual not-taken: expect redirect to 0x44, mispredict=1, flush_IF for 2 cycles.
- stall held 4 cycles with brch_instr_detectd_ID=1: pc_IF constant, no mispredict and no BTB write until stall drops.
- Wrap-around: RESET_PC=32'hFFFF_FFF8. Expect pc_IF sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/if_pc_pkg.sv
// Shared types for the fetch-stage PC generator: FSM states, reset PC and BTB entry layout.
// Types and constants only; no timing or flow-control behaviour.
package if_pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        RECOVER
    } state_t;

    localparam int PC_W  = 32;
    localparam int IDX_W = 5;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    // Entry layout at the default geometry; the array itself is parameterised in btb_dm.
    typedef struct packed {
        logic                    valid;
        logic [PC_W-IDX_W-3:0]   tag;
        logic [PC_W-3:0]         target;
    } btb_entry_t;

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped BTB storage: combinational read, registered write, reset clears valid bits.
// Read is zero-latency; a same-cycle write to the read index is seen from the next cycle; no backpressure.
module btb_dm #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 5,
    localparam int TAG_W = ADDR_W - IDX_W - 2,
    localparam int TGT_W = ADDR_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [TGT_W-1:0] rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [TGT_W-1:0] wr_target
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] valid;
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [TGT_W-1:0] tgt_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            tgt_mem[wr_idx] <= wr_target;
        end
    end

    assign rd_valid  = valid[rd_idx];
    assign rd_tag    = tag_mem[rd_idx];
    assign rd_target = tgt_mem[rd_idx];

endmodule

// File: rtl/if_pc_gen_btb.sv
// Fetch next-PC generator with direct-mapped BTB, ID-stage branch resolution and mispredict recovery.
// Predicted-taken redirect has zero bubbles, a mispredict costs two flushed IF slots; stall holds PC and blocks resolution.
module if_pc_gen_btb
    import if_pc_pkg::*;
#(
    parameter int ADDR_W    = PC_W,
    parameter int BTB_IDX_W = IDX_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 brch_instr_detectd_IF,
    input  logic                 prediction,
    input  logic                 brch_instr_detectd_ID,
    input  logic                 actual_brch_result,
    input  logic [ADDR_W-1:0]    brch_target_ID,
    output logic [ADDR_W-1:0]    pc_IF,
    output logic [BTB_IDX_W-1:0] branch_addr_lw_5b,
    output logic                 flush_IF,
    output logic                 mispredict
);

    localparam int TAG_W = ADDR_W - BTB_IDX_W - 2;

    state_t              state;
    logic                pred_taken_id;
    logic [ADDR_W-1:0]   pc4_id;

    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [ADDR_W-3:0]   rd_target;
    logic                hit;
    logic                pred_taken_if;
    logic                resolve;
    logic                btb_wr;
    logic [ADDR_W-3:0]   pc_id_word;
    logic [ADDR_W-1:0]   pc_plus4;
    logic [ADDR_W-1:0]   correct_pc;

    assign branch_addr_lw_5b = pc_IF[BTB_IDX_W+1:2];
    assign hit               = rd_valid && (rd_tag == pc_IF[ADDR_W-1:BTB_IDX_W+2]);
    assign pred_taken_if     = prediction & brch_instr_detectd_IF & hit;

    // Only RUN holds a real instruction in ID; BOOT and RECOVER carry bubbles.
    assign resolve    = brch_instr_detectd_ID & ~stall & ~rst & (state == RUN);
    assign mispredict = resolve & (actual_brch_result != pred_taken_id);
    assign flush_IF   = rst | (state != RUN) | mispredict;

    assign pc_plus4   = pc_IF + ADDR_W'(4);
    assign correct_pc = actual_brch_result ? brch_target_ID : pc4_id;
    assign pc_id_word = pc4_id[ADDR_W-1:2] - (ADDR_W-2)'(1);
    assign btb_wr     = resolve & actual_brch_result;

    btb_dm #(
        .ADDR_W (ADDR_W),
        .IDX_W  (BTB_IDX_W)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc_IF[BTB_IDX_W+1:2]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .wr_en     (btb_wr),
        .wr_idx    (pc_id_word[BTB_IDX_W-1:0]),
        .wr_tag    (pc_id_word[ADDR_W-3:BTB_IDX_W]),
        .wr_target (brch_target_ID[ADDR_W-1:2])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc_IF         <= RESET_PC;
            pred_taken_id <= 1'b0;
            pc4_id        <= '0;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (mispredict) state <= RECOVER;
                RECOVER: if (!stall) state <= RUN;
                default: state <= BOOT;
            endcase

            if (mispredict) begin
                pc_IF <= correct_pc;
            end else if (!stall) begin
                pc_IF <= pred_taken_if ? {rd_target, 2'b00} : pc_plus4;
            end

            if (flush_IF) begin
                pred_taken_id <= 1'b0;
            end else if (!stall) begin
                pred_taken_id <= pred_taken_if;
                pc4_id        <= pc_plus4;
            end
        end
    end

endmodule
